// File: rtl/serial_to_parallel_receiver.sv
// ============================================================================
// Module      : serial_to_parallel_receiver
// Description : LSB-first serial receiver with a one-word valid/ready holding
//               buffer, sticky overrun flag and optional even-parity check
//               (enabled by defining PARITY_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_to_parallel_receiver #(
    parameter int size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sdi,
    input  logic            sen,
    input  logic            clr,
    input  logic            out_ready,
    input  logic            ovr_clr,
    output logic [size-1:0] out_data,
    output logic            out_valid,
    output logic            ovr,
    output logic            par_err,
    output logic            busy
);

`ifdef PARITY_CHECK_EN
    localparam int FRAME = size + 1;
    localparam int SH_W  = size;
`else
    // The newest bit is taken straight from sdi at completion, so only
    // size-1 bits ever need to be held between edges.
    localparam int FRAME = size;
    localparam int SH_W  = size - 1;
`endif

    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(FRAME - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [SH_W-1:0]  r_shreg;
    logic [size-1:0]  r_out_data;
    logic             r_out_valid;
    logic             r_ovr;

    logic             w_at_last;
    logic             w_complete;
    logic             w_consume;
    logic             w_load;
    logic             w_overrun;
    logic [size-1:0]  w_word;
    logic [SH_W-1:0]  w_shift_nxt;
    logic             w_shift_en;

`ifdef PARITY_CHECK_EN
    logic             r_par_err;
    logic             w_par_bad;

    // The parity bit arrives after the data MSB and is compared, never stored.
    assign w_word      = r_shreg;
    assign w_shift_nxt = {sdi, r_shreg[size-1:1]};
    assign w_shift_en  = sen && !clr && !w_at_last;
    assign w_par_bad   = (^r_shreg) ^ sdi;
`else
    assign w_word      = {sdi, r_shreg};
    assign w_shift_nxt = w_word[size-1:1];
    assign w_shift_en  = sen && !clr;
`endif

    assign w_at_last  = (r_cnt == c_last_cnt);
    assign w_complete = sen && !clr && w_at_last;
    assign w_consume  = r_out_valid && out_ready;
    assign w_load     = w_complete && (!r_out_valid || out_ready);
    assign w_overrun  = w_complete && r_out_valid && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (sen) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (clr) begin
            r_shreg <= '0;
        end else if (w_shift_en) begin
            r_shreg <= w_shift_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_word;
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    // Overrun has priority over a simultaneous software clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr <= 1'b0;
        end else if (w_overrun) begin
            r_ovr <= 1'b1;
        end else if (ovr_clr) begin
            r_ovr <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_load) begin
            r_par_err <= w_par_bad;
        end else if (w_consume) begin
            r_par_err <= 1'b0;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign ovr       = r_ovr;
    assign busy      = (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_serial_to_parallel_receiver.sv
// ============================================================================
// Module      : tb_serial_to_parallel_receiver
// Description : Scoreboard bench for serial_to_parallel_receiver (size=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_to_parallel_receiver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sdi = 1'b0;
    logic         sen = 1'b0;
    logic         clr = 1'b0;
    logic         out_ready = 1'b0;
    logic         ovr_clr = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         ovr;
    logic         par_err;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] data;
        logic         perr;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   valid_cycles = 0;

    serial_to_parallel_receiver #(.size(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sdi       (sdi),
        .sen       (sen),
        .clr       (clr),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .ovr       (ovr),
        .par_err   (par_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: inputs change just after posedge, so the negedge sees the
    // handshake state that the next posedge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_data", 32'(out_data), 32'(e.data));
                    check("sb_par_err", 32'(par_err), 32'(e.perr));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sen = 1'b1;
        sdi = b;
        tick();
        sen = 1'b0;
        sdi = 1'b0;
    endtask

    // Sends a word LSB first; gap_mode=1 inserts k idle clocks after bit k.
    task automatic send_word(input logic [W-1:0] w, input bit gap_mode, input logic flip_par);
        logic [W-1:0] v;
        v = w;
        for (int k = 0; k < W; k++) begin
            send_bit(v[k]);
            if (gap_mode && k > 0 && k < W - 1) begin
                for (int g = 0; g < k; g++) tick();
                check("busy_in_gap", 32'(busy), 32'd1);
            end
        end
`ifdef PARITY_CHECK_EN
        send_bit((^v) ^ flip_par);
`endif
    endtask

    task automatic push(input logic [W-1:0] w, input logic flip_par);
        exp_t e;
        e.data = w;
`ifdef PARITY_CHECK_EN
        e.perr = flip_par;
`else
        e.perr = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset, then async reset mid-frame
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("busy_partial", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        send_word(4'hA, 1'b0, 1'b0);
        push(4'hA, 1'b0);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'hA);
        consume();

        // 2: basic word 1,0,1,1 -> D
        check("idle_valid", 32'(out_valid), 32'd0);
        send_word(4'hD, 1'b0, 1'b0);
        push(4'hD, 1'b0);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_data", 32'(out_data), 32'hD);
        check("basic_busy", 32'(busy), 32'd0);
        consume();
        check("basic_consumed", 32'(out_valid), 32'd0);

        // 3: gapped
        send_word(4'hD, 1'b1, 1'b0);
        push(4'hD, 1'b0);
        check("gap_data", 32'(out_data), 32'hD);
        consume();

        // 4: overrun (dropped word carries bad parity when enabled)
        send_word(4'h3, 1'b0, 1'b0);
        push(4'h3, 1'b0);
        send_word(4'hA, 1'b0, 1'b1);
        check("ovr_data_kept", 32'(out_data), 32'h3);
        check("ovr_set", 32'(ovr), 32'd1);
        check("ovr_valid", 32'(out_valid), 32'd1);
        consume();
        check("ovr_consumed", 32'(out_valid), 32'd0);
        check("ovr_sticky", 32'(ovr), 32'd1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_cleared", 32'(ovr), 32'd0);

        // 5: back-to-back with ready tied high
        valid_cycles = 0;
        out_ready = 1'b1;
        push(4'h1, 1'b0);
        send_word(4'h1, 1'b0, 1'b0);
        push(4'h2, 1'b0);
        send_word(4'h2, 1'b0, 1'b0);
        push(4'h3, 1'b0);
        send_word(4'h3, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        check("b2b_valid_cycles", 32'(valid_cycles), 32'd3);
        check("b2b_valid_low", 32'(out_valid), 32'd0);
        check("b2b_ovr", 32'(ovr), 32'd0);

        // 6: clr after 2 bits (sen at the clr edge ignored), then 0,0,0,1
        send_bit(1'b1);
        send_bit(1'b1);
        clr = 1'b1;
        sen = 1'b1;
        sdi = 1'b1;
        tick();
        clr = 1'b0;
        sen = 1'b0;
        sdi = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_no_valid", 32'(out_valid), 32'd0);
        send_word(4'h8, 1'b0, 1'b0);
        push(4'h8, 1'b0);
        check("clr_data", 32'(out_data), 32'h8);
        consume();

        // 6b: parity good then bad (par_err 0 throughout without parity)
        send_word(4'hD, 1'b0, 1'b0);
        push(4'hD, 1'b0);
        consume();
        send_word(4'hD, 1'b0, 1'b1);
        push(4'hD, 1'b1);
        consume();
        check("par_err_cleared", 32'(par_err), 32'd0);

        tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
